// File: rtl/aq_f_spsram_ctrl.sv
// aq_f_spsram_ctrl: single-port SRAM controller with behavioural storage,
// a power-up / on-request zero-fill sweep and a 1-cycle read path.
// Optional macro AQ_F_SPSRAM_CTRL_OUT_REG_EN adds an output register stage
// on Q/RVALID (read latency 2 instead of 1, throughput unchanged).
module aq_f_spsram_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  RVALID,
    output logic                  INIT_BUSY
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    logic run_acc;
    logic wr_en;
    logic rd_en;

    // An access is only honoured in RUN and is dropped when a sweep is requested
    assign run_acc = (state == ST_RUN) && !INIT_REQ && !CEN;
    assign wr_en   = run_acc && !GWEN;
    assign rd_en   = run_acc && GWEN;

    // Sweep/run state machine with registered busy flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (INIT_REQ) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage: zero-fill one entry per sweep cycle, otherwise bit-masked writes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == ST_INIT) begin
                mem[cnt] <= '0;
            end else if (wr_en) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end
        end
    end

    // Read stage: capture entry on a read, Q holds otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[A];
            end
        end
    end

    assign INIT_BUSY = busy;

`ifdef AQ_F_SPSRAM_CTRL_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  flush;

    // A read still in the first stage when a sweep starts is discarded
    assign flush = (state == ST_INIT) || INIT_REQ;

    // Output register stage, hold Q between completed reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_valid && !flush;
            if (rd_valid && !flush) begin
                out_data <= rd_data;
            end
        end
    end

    assign Q      = out_data;
    assign RVALID = out_valid;
`else
    assign Q      = rd_data;
    assign RVALID = rd_valid;
`endif

endmodule

// File: tb/tb_aq_f_spsram_ctrl.sv
// Scoreboard bench for aq_f_spsram_ctrl (64x88 default build).
module tb_aq_f_spsram_ctrl;

    localparam int AW = 6;
    localparam int DW = 88;
`ifdef AQ_F_SPSRAM_CTRL_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic          INIT_REQ;
    logic [DW-1:0] Q;
    logic          RVALID;
    logic          INIT_BUSY;

    aq_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .D(D), .INIT_REQ(INIT_REQ), .Q(Q), .RVALID(RVALID), .INIT_BUSY(INIT_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] pat [4];

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every RVALID pulse must match the oldest expected read
    always @(negedge CLK) begin
        if (RVALID === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid cyc=%0d got Q=%h required no RVALID", cyc, Q);
            end else begin
                mon_e = sb.pop_front();
                if (Q !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL read_data cyc=%0d got Q=%h required Q=%h at cyc %0d",
                             cyc, Q, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        CEN = 1'b1; GWEN = 1'b1; INIT_REQ = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
        A = a; D = d; WEN = wen; CEN = 1'b0; GWEN = 1'b0; INIT_REQ = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        exp_t e;
        A = a; CEN = 1'b0; GWEN = 1'b1; INIT_REQ = 1'b0;
        e.data = exp;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        tick();
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (INIT_BUSY === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(name, DW'(n), DW'(64));
    endtask

    initial begin
        int n;
        pat[0] = {22{4'hA}};
        pat[1] = {11{8'h3C}};
        pat[2] = {DW{1'b1}} >> 3;
        pat[3] = 88'h0123456789ABCDEF012345;

        RST = 1'b1; CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; A = '0; INIT_REQ = 1'b0;
        tick(); tick(); tick();
        chk("reset_q", Q, '0);
        chk("reset_rvalid", DW'(RVALID), '0);
        chk("reset_busy", DW'(INIT_BUSY), DW'(1));

        // Power-up sweep length, then the whole array reads zero
        RST = 1'b0;
        count_busy("powerup_busy_cycles");
        for (int i = 0; i < 64; i++) rd(AW'(i), '0);
        idle(4);

        // Full write then immediate read of the same address
        wr(6'd5, '1, '0);
        rd(6'd5, '1);
        // Partial write: only bits [7:0] enabled over a zeroed entry
        wr(6'd7, '1, ~(DW'(8'hFF)));
        rd(6'd7, DW'(8'hFF));
        idle(4);

        // Back-to-back reads of distinct patterns
        for (int i = 0; i < 4; i++) wr(AW'(i), pat[i], '0);
        for (int i = 0; i < 4; i++) rd(AW'(i), pat[i]);
        idle(4);
        // Q holds its last read value across a write and idle cycles
        wr(6'd20, '1, '0);
        idle(2);
        chk("q_hold_after_write", Q, pat[3]);

        // Sweep request with a simultaneous write; accesses during sweep ignored
        A = 6'd3; D = '1; WEN = '0; CEN = 1'b0; GWEN = 1'b0; INIT_REQ = 1'b1;
        tick();
        n = 0;
        while (INIT_BUSY === 1'b1 && n < 200) begin
            n++;
            CEN = 1'b0; GWEN = (n == 10) ? 1'b0 : 1'b1; WEN = '0; D = '1;
            A = (n == 10) ? 6'd2 : AW'(n);
            INIT_REQ = (n == 30);
            tick();
        end
        chk("init_req_busy_cycles", DW'(n), DW'(64));
        idle(1);
        rd(6'd3, '0);
        rd(6'd2, '0);
        idle(4);

        // Reset on cycle 20 of a sweep restarts the full sweep
        wr(6'd12, pat[1], '0);
        rd(6'd12, pat[1]);
        idle(3);
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        RST = 1'b1; CEN = 1'b0; GWEN = 1'b1; A = 6'd12;
        tick(); tick();
        chk("mid_sweep_rst_busy", DW'(INIT_BUSY), DW'(1));
        chk("mid_sweep_rst_q", Q, '0);
        RST = 1'b0; CEN = 1'b1;
        count_busy("mid_sweep_rst_busy_cycles");

        // Reset on the issue cycle of a read discards it
        wr(6'd12, pat[2], '0);
        rd(6'd12, pat[2]);
        idle(3);
        chk("pre_rst_q", Q, pat[2]);
        RST = 1'b1; CEN = 1'b0; GWEN = 1'b1; A = 6'd12;
        tick();
        CEN = 1'b1;
        tick();
        chk("read_rst_q", Q, '0);
        chk("read_rst_rvalid", DW'(RVALID), '0);
        RST = 1'b0;
        count_busy("read_rst_busy_cycles");
        rd(6'd12, '0);
        idle(5);
        chk("scoreboard_drained", DW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
